// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_mem.sv
// Entry storage for inst_queue: DEPTH entries, two write ports, two
// combinational read ports. The two write addresses never collide because
// the top always writes tail and tail+1.
module inst_queue_mem
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we0,
  input  logic [AW-1:0] waddr0,
  input  iq_entry_t     wdata0,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  iq_entry_t     wdata1,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output iq_entry_t     rdata0,
  output iq_entry_t     rdata1
);

  iq_entry_t mem_q [DEPTH];

  // Entries clear on reset so invalid slots never read as X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (we0) mem_q[waddr0] <= wdata0;
      if (we1) mem_q[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode. Circular FIFO with
// compacted two-wide enqueue and two-wide dequeue of the oldest entries.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              fetch_valid0_i,
  input  logic [PC_W-1:0]   fetch_pc0_i,
  input  logic [INST_W-1:0] fetch_inst0_i,
  input  logic              fetch_valid1_i,
  input  logic [PC_W-1:0]   fetch_pc1_i,
  input  logic [INST_W-1:0] fetch_inst1_i,
  output logic              fetch_ready_o,
  input  logic              dec_accept_i,
  output logic              inst0_f1_valid_o,
  output logic [PC_W-1:0]   inst0_f1_pc_o,
  output logic [INST_W-1:0] inst0_f1_inst_o,
  output logic              inst1_f1_valid_o,
  output logic [PC_W-1:0]   inst1_f1_pc_o,
  output logic [INST_W-1:0] inst1_f1_inst_o,
  output logic [CW-1:0]     count_o
);

  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] push_cnt, pop_cnt;
  logic          push_en;
  logic          we0, we1;
  iq_entry_t     slot0, slot1, wdata0, rd0, rd1;

  assign slot0 = '{pc: fetch_pc0_i, inst: fetch_inst0_i};
  assign slot1 = '{pc: fetch_pc1_i, inst: fetch_inst1_i};

  // Ready looks only at registered occupancy; a same-cycle pop never helps.
  assign fetch_ready_o    = (count_q <= CW'(DEPTH - 2));
  assign inst0_f1_valid_o = (count_q >= CW'(1));
  assign inst1_f1_valid_o = (count_q >= CW'(2));
  assign count_o          = count_q;

  // Compact the valid fetch slots onto tail / tail+1.
  always_comb begin
    push_en  = fetch_ready_o && !flush_i;
    we0      = push_en && (fetch_valid0_i || fetch_valid1_i);
    we1      = push_en && fetch_valid0_i && fetch_valid1_i;
    wdata0   = fetch_valid0_i ? slot0 : slot1;
    push_cnt = push_en ? (CW'(fetch_valid0_i) + CW'(fetch_valid1_i)) : '0;
    pop_cnt  = dec_accept_i ? (CW'(inst0_f1_valid_o) + CW'(inst1_f1_valid_o)) : '0;
  end

  inst_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we0    (we0),
    .waddr0 (tail_q),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (tail_q + AW'(1)),
    .wdata1 (slot1),
    .raddr0 (head_q),
    .raddr1 (head_q + AW'(1)),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  assign inst0_f1_pc_o   = rd0.pc;
  assign inst0_f1_inst_o = rd0.inst;
  assign inst1_f1_pc_o   = rd1.pc;
  assign inst1_f1_inst_o = rd1.inst;

  // Pointer and occupancy update; flush discards same-cycle push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + AW'(pop_cnt);
      tail_q  <= tail_q + AW'(push_cnt);
      count_q <= count_q + push_cnt - pop_cnt;
    end
  end

endmodule
